// File: rtl/axil_read_mo_if.sv
// axil_read_mo_if: AXI4-Lite read channels plus the config-side request/result port.
// master = the read engine, slave = the AXI slave / config client.
interface axil_read_mo_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              s_axi_cfg_rvalid;
    logic [ADDR_W-1:0] s_axi_cfg_raddr;
    logic              s_axi_cfg_rready;
    logic [DATA_W-1:0] s_axi_cfg_rdata;
    logic [ADDR_W-1:0] s_axi_cfg_rdaddr;
    logic [1:0]        s_axi_cfg_rresp;
    logic              s_axi_cfg_rdv;
    logic              s_axi_cfg_busy;
    logic              s_axi_cfg_timeout;

    modport master (
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_cfg_rready, s_axi_cfg_rdata, s_axi_cfg_rdaddr,
        output s_axi_cfg_rresp, s_axi_cfg_rdv, s_axi_cfg_busy,
        output s_axi_cfg_timeout,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_cfg_rvalid, s_axi_cfg_raddr
    );

    modport slave (
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_cfg_rready, s_axi_cfg_rdata, s_axi_cfg_rdaddr,
        input  s_axi_cfg_rresp, s_axi_cfg_rdv, s_axi_cfg_busy,
        input  s_axi_cfg_timeout,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_cfg_rvalid, s_axi_cfg_raddr
    );
endinterface

// File: rtl/axil_read_mo.sv
// axil_read_mo: queued AXI4-Lite read master with multiple outstanding reads.
// Optional R-wait timeout enabled by defining AXIL_RD_TIMEOUT_EN.
module axil_read_mo #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CMD_DEPTH   = 4,
    parameter int MAX_OUT     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic s_axi_aclk,
    input logic s_axi_areset,
    axil_read_mo_if.master bus
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [ADDR_W-1:0] cmd_mem_q [CMD_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              rdy_q, full_d;
    logic [ADDR_W-1:0] ifl_mem_q [MAX_OUT];
    logic [IW-1:0]     ifl_wr_q, ifl_rd_q;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              rdv_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [ADDR_W-1:0] rdaddr_q;

    logic              fifo_empty, push, pop, bypass;
    logic              ar_hs, r_hs, room, retire, to_fire;
    logic [ADDR_W-1:0] head_addr;

    function automatic logic [IW-1:0] ifl_inc(input logic [IW-1:0] i);
        return (i == IW'(MAX_OUT - 1)) ? '0 : i + IW'(1);
    endfunction

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = bus.s_axi_cfg_rvalid && rdy_q;
    assign ar_hs      = arvalid_q && bus.s_axi_arready;
    assign r_hs       = bus.s_axi_rvalid && (out_cnt_q != '0);
    assign retire     = r_hs || to_fire;
    assign room       = ({1'b0, out_cnt_q} + {{CW{1'b0}}, arvalid_q})
                        < (CW+1)'(MAX_OUT);
    // An empty queue forwards the incoming request straight onto AR.
    assign pop        = (!arvalid_q || bus.s_axi_arready)
                        && (!fifo_empty || push) && room;
    assign bypass     = pop && fifo_empty;
    assign head_addr  = fifo_empty ? bus.s_axi_cfg_raddr
                                   : cmd_mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !bypass) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop && !fifo_empty) rd_ptr_d = rd_ptr_q + PW'(1);
        full_d = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1])
                 && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        out_cnt_d = out_cnt_q;
        case ({ar_hs, retire})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (push && !bypass) cmd_mem_q[wr_ptr_q[AW-1:0]] <= bus.s_axi_cfg_raddr;
        if (ar_hs) ifl_mem_q[ifl_wr_q] <= araddr_q;
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rdy_q     <= 1'b0;
            ifl_wr_q  <= '0;
            ifl_rd_q  <= '0;
            out_cnt_q <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rdaddr_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rdy_q     <= !full_d;
            out_cnt_q <= out_cnt_d;
            if (ar_hs) ifl_wr_q <= ifl_inc(ifl_wr_q);
            if (retire) ifl_rd_q <= ifl_inc(ifl_rd_q);
            if (pop) begin
                arvalid_q <= 1'b1;
                araddr_q  <= head_addr;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
            rdv_q <= retire;
            if (r_hs) begin
                rdata_q  <= bus.s_axi_rdata;
                rresp_q  <= bus.s_axi_rresp;
                rdaddr_q <= ifl_mem_q[ifl_rd_q];
            end else if (to_fire) begin
                rdata_q  <= '0;
                rresp_q  <= 2'b10;
                rdaddr_q <= ifl_mem_q[ifl_rd_q];
            end
        end
    end

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q;
    logic          timeout_q;

    // Counter starts the cycle after AR, so the strobe lands TIMEOUT_CYC after it.
    assign to_fire = (out_cnt_q != '0) && !r_hs
                     && (to_cnt_q == TW'(TIMEOUT_CYC - 2));

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (out_cnt_q == '0 || r_hs || to_fire) to_cnt_q <= '0;
            else to_cnt_q <= to_cnt_q + TW'(1);
            if (to_fire) timeout_q <= 1'b1;
        end
    end

    assign bus.s_axi_cfg_timeout = timeout_q;
`else
    assign to_fire = 1'b0;
    assign bus.s_axi_cfg_timeout = 1'b0;
`endif

    assign bus.s_axi_araddr     = araddr_q;
    assign bus.s_axi_arvalid    = arvalid_q;
    assign bus.s_axi_rready     = (out_cnt_q != '0);
    assign bus.s_axi_cfg_rready = rdy_q;
    assign bus.s_axi_cfg_rdata  = rdata_q;
    assign bus.s_axi_cfg_rdaddr = rdaddr_q;
    assign bus.s_axi_cfg_rresp  = rresp_q;
    assign bus.s_axi_cfg_rdv    = rdv_q;
    assign bus.s_axi_cfg_busy   = !fifo_empty || arvalid_q || (out_cnt_q != '0);
endmodule
